// File: rtl/cordic_pkg.sv
// Shared constants, state encoding and constant-narrowing helper for the CORDIC trig unit.
// All angle/value constants are Q2.30; narrower datapaths shift them down arithmetically.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } cordic_state_e;

    localparam logic [31:0] K_Q30    = 32'h26DD3B6A;
    localparam logic [31:0] PI_Q30   = 32'hC90FDAA2;
    localparam logic [31:0] PI_2_Q30 = 32'h6487ED51;

    // atan(2^-i) in Q2.30, rounded to nearest
    localparam logic [31:0] ATAN_TAB [0:31] = '{
        32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
        32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
        32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
        32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
        32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
        32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
        32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
        32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
    };

    // Treats a Q2.30 constant as a non-negative 34-bit value and narrows it to Q2.(width-2).
    function automatic logic signed [33:0] narrow34(input logic [31:0] c, input int width);
        logic signed [33:0] wide;
        wide = $signed({2'b00, c});
        return wide >>> (32 - width);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation in rotation mode.
// Direction follows the sign of the residual angle; zero counts as positive.
module cordic_stage #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic signed [WIDTH-1:0] z_i,
    input  logic        [4:0]       shift_i,
    input  logic signed [WIDTH-1:0] atan_i,
    output logic signed [WIDTH-1:0] x_o,
    output logic signed [WIDTH-1:0] y_o,
    output logic signed [WIDTH-1:0] z_o
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;

    always_comb begin
        x_sh = x_i >>> shift_i;
        y_sh = y_i >>> shift_i;
        if (z_i[WIDTH-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end
    end

endmodule

// File: rtl/cordic_trig_unit.sv
// Iterative CORDIC cos/sin engine behind the clk_en/start/done multi-cycle handshake.
// Angles beyond +/-pi/2 are folded into range and the cosine sign is restored at the end.
import cordic_pkg::*;

module cordic_trig_unit #(
    parameter int WIDTH  = 32,
    parameter int ITERS  = 16,
    parameter int UNROLL = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic                    start,
    input  logic                    sel,
    input  logic signed [WIDTH-1:0] theta,
    output logic                    done,
    output logic        [WIDTH-1:0] result,
    output cordic_state_e           state_dbg
);

    // Handshake: with clk_en=1, start is accepted only in IDLE or FIN (sel/theta latched
    // on that edge); done is a single enabled-cycle pulse and result holds until the next one.

    if (ITERS % UNROLL != 0) begin : g_bad_unroll
        $error("cordic_trig_unit: UNROLL must divide ITERS");
    end
    if (WIDTH < 16 || WIDTH > 32 || ITERS < 4 || ITERS > WIDTH - 2) begin : g_bad_size
        $error("cordic_trig_unit: WIDTH or ITERS out of range");
    end

    localparam logic signed [WIDTH+1:0] PI_N   = (WIDTH+2)'(narrow34(PI_Q30, WIDTH));
    localparam logic signed [WIDTH-1:0] PI_2_N = WIDTH'(narrow34(PI_2_Q30, WIDTH));
    localparam logic signed [WIDTH-1:0] K_N    = WIDTH'(narrow34(K_Q30, WIDTH));

    cordic_state_e           state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic        [4:0]       i_q, i_d;
    logic                    sel_q, sel_d, neg_q, neg_d;
    logic        [WIDTH-1:0] result_q, result_d;
    logic                    done_q, done_d;

    logic signed [WIDTH+1:0] th_ext;
    logic signed [WIDTH-1:0] z_load;
    logic                    neg_load;
    logic                    do_load;
    logic                    last_step;

    logic signed [WIDTH-1:0] xs [UNROLL+1];
    logic signed [WIDTH-1:0] ys [UNROLL+1];
    logic signed [WIDTH-1:0] zs [UNROLL+1];

    assign xs[0] = x_q;
    assign ys[0] = y_q;
    assign zs[0] = z_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_stage
        logic        [4:0]       idx;
        logic signed [WIDTH-1:0] atan_w;

        assign idx    = i_q + 5'(k);
        assign atan_w = WIDTH'(narrow34(ATAN_TAB[idx], WIDTH));

        cordic_stage #(.WIDTH(WIDTH)) u_stage (
            .x_i     (xs[k]),
            .y_i     (ys[k]),
            .z_i     (zs[k]),
            .shift_i (idx),
            .atan_i  (atan_w),
            .x_o     (xs[k+1]),
            .y_o     (ys[k+1]),
            .z_o     (zs[k+1])
        );
    end

    // Quadrant fold: the cosine of an angle mirrored about +/-pi/2 changes sign, sine does not
    always_comb begin
        th_ext   = {{2{theta[WIDTH-1]}}, theta};
        z_load   = theta;
        neg_load = 1'b0;
        if (theta > PI_2_N) begin
            z_load   = WIDTH'(PI_N - th_ext);
            neg_load = 1'b1;
        end else if (theta < -PI_2_N) begin
            z_load   = WIDTH'(-PI_N - th_ext);
            neg_load = 1'b1;
        end
    end

    assign do_load   = start && (state_q == ST_IDLE || state_q == ST_FIN);
    assign last_step = (i_q + 5'(UNROLL)) == 5'(ITERS);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        i_d      = i_q;
        sel_d    = sel_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                x_d = xs[UNROLL];
                y_d = ys[UNROLL];
                z_d = zs[UNROLL];
                i_d = i_q + 5'(UNROLL);
                if (last_step) begin
                    result_d = sel_q ? ys[UNROLL] : (neg_q ? -xs[UNROLL] : xs[UNROLL]);
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (do_load) begin
            x_d     = K_N;
            y_d     = '0;
            z_d     = z_load;
            i_d     = '0;
            sel_d   = sel;
            neg_d   = neg_load;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            i_q      <= '0;
            sel_q    <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            i_q      <= i_d;
            sel_q    <= sel_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done      = done_q;
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_cordic_trig_unit.sv
// Self-checking bench for cordic_trig_unit: real-math cos/sin reference, latency and
// handshake checks on a default instance and a WIDTH=24 / UNROLL=4 instance.
module tb_cordic_trig_unit;
    import cordic_pkg::*;

    localparam int TOL32 = 32'h10000;
    localparam int TOL24 = 32'h400;

    logic          clk = 1'b0;
    logic          reset, clk_en, start, sel;
    logic [31:0]   theta;
    logic          done;
    logic [31:0]   result;
    cordic_state_e st;

    logic          start4, sel4;
    logic [23:0]   theta4;
    logic          done4;
    logic [23:0]   result4;
    cordic_state_e st4;

    int tests = 0;
    int fails = 0;

    logic        k_sel [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] k_th  [6] = '{32'h40000000, 32'hC0000000, 32'h7999999A,
                               32'h7999999A, 32'h86666666, 32'h86666666};

    always #5 clk = ~clk;

    cordic_trig_unit u_dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .start     (start),
        .sel       (sel),
        .theta     (theta),
        .done      (done),
        .result    (result),
        .state_dbg (st)
    );

    cordic_trig_unit #(.WIDTH(24), .ITERS(16), .UNROLL(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .start     (start4),
        .sel       (sel4),
        .theta     (theta4),
        .done      (done4),
        .result    (result4),
        .state_dbg (st4)
    );

    // Reference: true cos/sin of the fixed-point angle, rounded back to fixed point.
    function automatic int model(input logic s, input int th, input int width);
        real scale, a, v;
        scale = $itor(1 << (width - 2));
        a = $itor(th) / scale;
        v = s ? $sin(a) : $cos(a);
        return $rtoi(v * scale + ((v >= 0.0) ? 0.5 : -0.5));
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic run_op(input logic s, input logic [31:0] th, output logic [31:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; sel = s; theta = th;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        res = result;
        if (!done) lat = -1;
    endtask

    task automatic run_op4(input logic s, input logic [23:0] th, output logic [23:0] res, output int lat);
        @(negedge clk);
        start4 = 1'b1; sel4 = s; theta4 = th;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (done4) break;
        end
        res = result4;
        if (!done4) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_en = 1'b1; start = 1'b0; sel = 1'b0; theta = '0;
        start4 = 1'b0; sel4 = 1'b0; theta4 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", done); end
        tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %08h expected 0", result); end
        tests++; if (st !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", st, ST_IDLE); end
        tests++; if (done4 !== 1'b0 || result4 !== 24'h0) begin
            fails++; $display("FAIL reset_u4: got done=%0b result=%06h expected 0/0", done4, result4);
        end
    endtask

    task automatic test_cos_zero();
        int lat, exp;
        logic early_nz;
        early_nz = 1'b0;
        @(negedge clk);
        start = 1'b1; sel = 1'b0; theta = 32'h0;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (result !== 32'h0) early_nz = 1'b1;
        end
        exp = model(1'b0, 0, 32);
        tests++; if (early_nz !== 1'b0) begin fails++; $display("FAIL cos0_early_result: got nonzero expected 0"); end
        tests++; if (lat !== 16) begin fails++; $display("FAIL cos0_latency: got %0d expected 16", lat); end
        tests++; if (absdiff(int'($signed(result)), exp) > TOL32) begin
            fails++; $display("FAIL cos0_value: got %08h expected %08h", result, exp);
        end
    endtask

    task automatic test_known();
        logic [31:0] res;
        int lat, exp;
        for (int i = 0; i < 6; i++) begin
            run_op(k_sel[i], k_th[i], res, lat);
            exp = model(k_sel[i], int'($signed(k_th[i])), 32);
            tests++; if (lat !== 16) begin fails++; $display("FAIL known%0d_latency: got %0d expected 16", i, lat); end
            tests++; if (absdiff(int'($signed(res)), exp) > TOL32) begin
                fails++; $display("FAIL known%0d_value: got %08h expected %08h", i, res, exp);
            end
            if (i == 0) begin
                @(negedge clk);
                tests++; if (done !== 1'b0 || result !== res) begin
                    fails++; $display("FAIL known_hold: got done=%0b result=%08h expected 0/%08h", done, result, res);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] res, th;
        logic s;
        int lat, exp;
        for (int i = 0; i < 24; i++) begin
            s  = 1'($urandom_range(0, 1));
            th = $urandom;
            run_op(s, th, res, lat);
            exp = model(s, int'($signed(th)), 32);
            tests++; if (lat !== 16) begin fails++; $display("FAIL rand%0d_latency: got %0d expected 16", i, lat); end
            tests++; if (absdiff(int'($signed(res)), exp) > TOL32) begin
                fails++; $display("FAIL rand%0d_value sel=%0b th=%08h: got %08h expected %08h", i, s, th, res, exp);
            end
        end
    endtask

    task automatic test_start_during_run();
        int lat, exp, extra;
        @(negedge clk);
        start = 1'b1; sel = 1'b0; theta = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin start = 1'b1; sel = 1'b1; theta = 32'hC0000000; end
            if (lat == 6) start = 1'b0;
            if (done) break;
        end
        exp = model(1'b0, 32'h40000000, 32);
        tests++; if (lat !== 16) begin fails++; $display("FAIL ignore_latency: got %0d expected 16", lat); end
        tests++; if (absdiff(int'($signed(result)), exp) > TOL32) begin
            fails++; $display("FAIL ignore_value: got %08h expected %08h", result, exp);
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL ignore_no_requeue: got %0d extra done expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        int cyc, t1, t2, exp1, exp2;
        logic [31:0] r1, r2;
        logic mid_done;
        t1 = -1; t2 = -1; mid_done = 1'b1; r1 = '0; r2 = '0;
        @(negedge clk);
        start = 1'b1; sel = 1'b0; theta = 32'h2AAAAAAB;
        @(negedge clk);
        sel = 1'b1; theta = 32'hA0000000;
        cyc = 0;
        while (cyc < 200 && t2 < 0) begin
            @(negedge clk);
            cyc++;
            if (t1 >= 0 && cyc == t1 + 1) begin start = 1'b0; mid_done = done; end
            if (done) begin
                if (t1 < 0) begin t1 = cyc; r1 = result; end
                else begin t2 = cyc; r2 = result; end
            end
        end
        start = 1'b0;
        exp1 = model(1'b0, 32'h2AAAAAAB, 32);
        exp2 = model(1'b1, int'($signed(32'hA0000000)), 32);
        tests++; if (t1 !== 16) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 16", t1); end
        tests++; if (t2 - t1 !== 17) begin fails++; $display("FAIL b2b_spacing: got %0d expected 17", t2 - t1); end
        tests++; if (mid_done !== 1'b0) begin fails++; $display("FAIL b2b_done_clear: got %0b expected 0", mid_done); end
        tests++; if (absdiff(int'($signed(r1)), exp1) > TOL32) begin
            fails++; $display("FAIL b2b_value1: got %08h expected %08h", r1, exp1);
        end
        tests++; if (absdiff(int'($signed(r2)), exp2) > TOL32) begin
            fails++; $display("FAIL b2b_value2: got %08h expected %08h", r2, exp2);
        end
    endtask

    task automatic test_clk_en_stall();
        int lat, exp;
        logic [31:0] held;
        @(negedge clk);
        start = 1'b1; sel = 1'b1; theta = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 7) clk_en = 1'b0;
            if (lat == 12) clk_en = 1'b1;
            if (done) break;
        end
        exp = model(1'b1, 32'h40000000, 32);
        tests++; if (lat !== 21) begin fails++; $display("FAIL stall_latency: got %0d expected 21", lat); end
        tests++; if (absdiff(int'($signed(result)), exp) > TOL32) begin
            fails++; $display("FAIL stall_value: got %08h expected %08h", result, exp);
        end
        held = result;
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (done !== 1'b1 || result !== held) begin
            fails++; $display("FAIL stall_fin_hold: got done=%0b result=%08h expected 1/%08h", done, result, held);
        end
        clk_en = 1'b1;
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL stall_fin_clear: got %0b expected 0", done); end
    endtask

    task automatic test_reset_mid_run();
        int lat, exp, pulses;
        logic nz;
        logic [31:0] res;
        @(negedge clk);
        start = 1'b1; sel = 1'b0; theta = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (result !== 32'h0 || done !== 1'b0) begin
            fails++; $display("FAIL midreset_clear: got done=%0b result=%08h expected 0/0", done, result);
        end
        pulses = 0; nz = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done) pulses++;
            if (result !== 32'h0) nz = 1'b1;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d pulses expected 0", pulses); end
        tests++; if (nz !== 1'b0) begin fails++; $display("FAIL midreset_result_zero: got nonzero expected 0"); end
        run_op(1'b1, 32'h1C71C71C, res, lat);
        exp = model(1'b1, 32'h1C71C71C, 32);
        tests++; if (lat !== 16) begin fails++; $display("FAIL midreset_restart_latency: got %0d expected 16", lat); end
        tests++; if (absdiff(int'($signed(res)), exp) > TOL32) begin
            fails++; $display("FAIL midreset_restart_value: got %08h expected %08h", res, exp);
        end
    endtask

    task automatic test_unroll4();
        logic [23:0] res, th;
        logic s;
        int lat, exp;
        run_op4(1'b0, 24'h400000, res, lat);
        exp = model(1'b0, 32'h400000, 24);
        tests++; if (lat !== 4) begin fails++; $display("FAIL u4_cos1_latency: got %0d expected 4", lat); end
        tests++; if (absdiff(int'($signed(res)), exp) > TOL24) begin
            fails++; $display("FAIL u4_cos1_value: got %06h expected %06h", res, exp);
        end
        for (int i = 0; i < 10; i++) begin
            s  = 1'($urandom_range(0, 1));
            th = 24'($urandom);
            run_op4(s, th, res, lat);
            exp = model(s, int'($signed(th)), 24);
            tests++; if (lat !== 4) begin fails++; $display("FAIL u4_rand%0d_latency: got %0d expected 4", i, lat); end
            tests++; if (absdiff(int'($signed(res)), exp) > TOL24) begin
                fails++; $display("FAIL u4_rand%0d_value sel=%0b th=%06h: got %06h expected %06h", i, s, th, res, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; start = 1'b0; sel = 1'b0; theta = '0;
        start4 = 1'b0; sel4 = 1'b0; theta4 = '0;
        test_reset();
        test_cos_zero();
        test_known();
        test_random();
        test_start_during_run();
        test_back_to_back();
        test_clk_en_stall();
        test_reset_mid_run();
        test_unroll4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
